// File: rtl/seq_restoring_divider_if.sv
// Operand/result handshake bundle for seq_restoring_divider.
// master: the block issuing divisions and consuming results.
// slave:  the divider.
interface seq_restoring_divider_if #(
  parameter int BITS = 8
);
  logic            in_valid;
  logic            in_ready;
  logic [BITS-1:0] dividend;
  logic [BITS-1:0] divisor;
  logic            out_valid;
  logic            out_ready;
  logic [BITS-1:0] quotient;
  logic [BITS-1:0] remainder;
  logic            div_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_zero
  );
endinterface

// File: rtl/seq_restoring_divider.sv
// Iterative radix-2 restoring divider, one quotient bit per cycle.
// One division in flight; valid/ready on operand and result sides.
// Divide-by-zero bypasses CALC and returns quotient=all ones,
// remainder=dividend, div_zero=1.
// Optional macro SEQ_DIVIDER_SIGNED_EN: two's-complement operands with
// truncating division (magnitudes divided, signs fixed up on entry to DONE).
module seq_restoring_divider #(
  parameter int BITS = 8
) (
  input logic                  clk,
  input logic                  rst,
  seq_restoring_divider_if.slave bus
);
  localparam int CW = (BITS > 2) ? $clog2(BITS) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_q, state_d;
  logic [BITS-1:0] q_q, q_d;       // dividend shifts out, quotient shifts in
  logic [BITS-1:0] d_q, d_d;       // divisor
  logic [BITS:0]   r_q, r_d;       // partial remainder, one guard bit
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            rdy_q, rdy_d;
  logic [BITS-1:0] quo_q, quo_d;
  logic [BITS-1:0] rem_q, rem_d;
  logic            dz_q, dz_d;

  logic [BITS:0]   rs, diff, r_step;
  logic [BITS-1:0] q_step, r_low, a_mag, b_mag;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic sn_q, sn_d, sd_q, sd_d;    // dividend / divisor sign at accept
`endif

  // Next-state, datapath step and result capture
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    d_d     = d_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
`ifdef SEQ_DIVIDER_SIGNED_EN
    sn_d    = sn_q;
    sd_d    = sd_q;
    a_mag   = bus.dividend[BITS-1] ? -bus.dividend : bus.dividend;
    b_mag   = bus.divisor[BITS-1]  ? -bus.divisor  : bus.divisor;
`else
    a_mag   = bus.dividend;
    b_mag   = bus.divisor;
`endif

    // Trial subtraction; a borrow in the guard bit means restore.
    rs     = {r_q[BITS-1:0], q_q[BITS-1]};
    diff   = rs - {1'b0, d_q};
    r_step = diff[BITS] ? rs : diff;
    q_step = {q_q[BITS-2:0], ~diff[BITS]};
    r_low  = r_step[BITS-1:0];

    case (state_q)
      IDLE: begin
        if (bus.in_valid && rdy_q) begin
          q_d   = a_mag;
          d_d   = b_mag;
          r_d   = '0;
          cnt_d = CW'(BITS - 1);
`ifdef SEQ_DIVIDER_SIGNED_EN
          sn_d  = bus.dividend[BITS-1];
          sd_d  = bus.divisor[BITS-1];
`endif
          if (bus.divisor == '0) begin
            state_d = DONE;
            quo_d   = '1;
            rem_d   = bus.dividend;
            dz_d    = 1'b1;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        q_d   = q_step;
        r_d   = r_step;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = DONE;
          dz_d    = 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
          quo_d   = (sn_q ^ sd_q) ? -q_step : q_step;
          rem_d   = sn_q ? -r_low : r_low;
`else
          quo_d   = q_step;
          rem_d   = r_low;
`endif
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Registered so in_ready stays low throughout reset and rises the
    // cycle after release or after the result handshake.
    rdy_d = (state_d == IDLE);
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      q_q     <= '0;
      d_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      sn_q    <= 1'b0;
      sd_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      d_q     <= d_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
`ifdef SEQ_DIVIDER_SIGNED_EN
      sn_q    <= sn_d;
      sd_q    <= sd_d;
`endif
    end
  end

  assign bus.in_ready  = rdy_q;
  assign bus.out_valid = (state_q == DONE);
  assign bus.quotient  = quo_q;
  assign bus.remainder = rem_q;
  assign bus.div_zero  = dz_q;
endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed bench for seq_restoring_divider (BITS=8). Stimulus pushes the
// expected {div_zero, quotient, remainder} into a queue; a monitor pops and
// compares on every result handshake.
module tb_seq_restoring_divider;
  localparam int BITS = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_restoring_divider_if #(.BITS(BITS)) bus ();

  seq_restoring_divider #(.BITS(BITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  logic [2*BITS:0] exp_q[$];
  logic [2*BITS:0] mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Result monitor: a handshake happens on the next posedge
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result actual q=%0h r=%0h required none",
                 bus.quotient, bus.remainder);
      end else begin
        mon_e = exp_q.pop_front();
        chk("quotient",  {24'd0, bus.quotient},  {24'd0, mon_e[2*BITS-1:BITS]});
        chk("remainder", {24'd0, bus.remainder}, {24'd0, mon_e[BITS-1:0]});
        chk("div_zero",  {31'd0, bus.div_zero},  {31'd0, mon_e[2*BITS]});
      end
    end
  end

  // Wait for in_ready (bounded) then present operands for one accept edge
  task automatic issue(input logic [BITS-1:0] a, input logic [BITS-1:0] b);
    int n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("in_ready_before_accept", {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.dividend = 8'hA5;   // changes after accept must be ignored
    bus.divisor  = 8'h00;
  endtask

  // One full division; accept edge counts as edge 1 for latency.
  task automatic run_div(input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                         input logic [BITS-1:0] eq, input logic [BITS-1:0] er,
                         input logic edz, input int elat, input int hold);
    int n;
    exp_q.push_back({edz, eq, er});
    issue(a, b);
    n = 1;
    while (!bus.out_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("latency", n, elat);
    for (int i = 0; i < hold; i++) begin
      chk("hold_out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("hold_quotient",  {24'd0, bus.quotient},  {24'd0, eq});
      chk("hold_remainder", {24'd0, bus.remainder}, {24'd0, er});
      chk("hold_in_ready",  {31'd0, bus.in_ready},  32'd0);
      bus.in_valid = (i % 2 == 0);
      bus.dividend = 8'd50;
      bus.divisor  = 8'd3;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("out_valid_after_hs", {31'd0, bus.out_valid}, 32'd0);
    chk("in_ready_after_hs",  {31'd0, bus.in_ready},  32'd1);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd0);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_quotient",  {24'd0, bus.quotient},  32'd0);
    chk("rst_remainder", {24'd0, bus.remainder}, 32'd0);
    chk("rst_div_zero",  {31'd0, bus.div_zero},  32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("in_ready_after_release", {31'd0, bus.in_ready}, 32'd1);

    run_div(8'd100, 8'd7,  8'd14,  8'd2,   1'b0, 9, 0);
    run_div(8'd3,   8'd10, 8'd0,   8'd3,   1'b0, 9, 0);
    run_div(8'd255, 8'd1,  8'd255, 8'd0,   1'b0, 9, 0);
    run_div(8'd5,   8'd0,  8'hFF,  8'd5,   1'b1, 1, 0);
    run_div(8'd9,   8'd3,  8'd3,   8'd0,   1'b0, 9, 0);

    bus.out_ready = 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
    run_div(8'd200, 8'd9,  8'hFA,  8'hFE,  1'b0, 9, 5);   // -56/9
`else
    run_div(8'd200, 8'd9,  8'd22,  8'd2,   1'b0, 9, 5);
`endif

    // Reset in the middle of CALC: result discarded, outputs cleared
    issue(8'd77, 8'd5);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("midrst_quotient",  {24'd0, bus.quotient},  32'd0);
    chk("midrst_remainder", {24'd0, bus.remainder}, 32'd0);
    chk("midrst_in_ready",  {31'd0, bus.in_ready},  32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("no_result_after_rst", {31'd0, bus.out_valid}, 32'd0);
    run_div(8'd77,  8'd5,  8'd15,  8'd2,   1'b0, 9, 0);

`ifdef SEQ_DIVIDER_SIGNED_EN
    run_div(8'h9C,  8'd7,  8'hF2,  8'hFE,  1'b0, 9, 0);
    run_div(8'd100, 8'hF9, 8'hF2,  8'h02,  1'b0, 9, 0);
    run_div(8'h80,  8'hFF, 8'h80,  8'h00,  1'b0, 9, 0);
`endif

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seq_restoring_divider.md
Name: seq_restoring_divider

Overview:
- Iterative radix-2 restoring unsigned integer divider. Retires one quotient bit per cycle using a BITS+1-bit trial subtraction, the inverse operation of the CPA adders.
- Sits beside the CPA library as the shared divide unit for datapath blocks.
- valid/ready handshake on both the operand side and the result side.
- Non-pipelined: one division in flight at a time.

Parameters:
- BITS, 8, operand/result width; supported 2..64.

Ports:
- clk  input  1  system clock; one clock; reset is asynchronous and active-high.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  divider can accept operands.
- dividend  input  BITS  numerator.
- divisor  input  BITS  denominator.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- quotient  output  BITS  dividend / divisor.
- remainder  output  BITS  dividend % divisor.
- div_zero  output  1  divisor was zero for this result.

Behaviour:
- Reset values: in_ready=0 while rst is high, 1 on the first cycle after release (state IDLE). out_valid=0, quotient=0, remainder=0, div_zero=0. All internal registers cleared.
- States:
  - IDLE: in_ready=1, out_valid=0. Accept on the edge where in_valid&&in_ready. Latch dividend into the Q shift register, divisor into D, clear R (BITS+1 bits), load counter=BITS-1, go to CALC. If divisor==0 at accept, go to DONE instead.
  - CALC: in_ready=0. Each cycle:
    - Rs={R[BITS-1:0],Q[BITS-1]}.
    - diff=Rs-{1'b0,D}, width BITS+1.
    - If diff[BITS]==0: R=diff, Q={Q[BITS-2:0],1}. Else: R=Rs, Q={Q[BITS-2:0],0}.
    - Counter decrements. When counter==0, the same edge goes to DONE.
  - DONE: out_valid=1, with quotient=Q and remainder=R[BITS-1:0]. Leave for IDLE on out_valid&&out_ready.
- Latency: accept edge at cycle 0 → out_valid high after edge BITS+1, i.e. exactly BITS CALC cycles. Divide-by-zero: out_valid high after edge 1.
- Divide-by-zero result: quotient=all ones, remainder=dividend, div_zero=1. div_zero=0 for every other result.
- Backpressure: while out_valid&&!out_ready, quotient/remainder/div_zero/out_valid hold stable. in_ready stays 0.
- No acceptance in CALC or DONE: in_ready=0, and input changes are ignored.
- Throughput: one division per BITS+2 cycles, counting the IDLE cycle after the result handshake.
- Result registers update only on entry to DONE; outside DONE they hold the last result.
- Divisor > dividend: quotient=0, remainder=dividend. Divisor=1: quotient=dividend, remainder=0.
- rst asserted in any state, including mid-CALC: immediately to IDLE with reset output values. The in-flight operation is discarded and produces no result.

Optional Feature:
- Macro: SEQ_DIVIDER_SIGNED_EN.
- Defined:
  - Operands and results are two's complement.
  - At accept, magnitudes of dividend/divisor are latched and the two sign bits are stored.
  - On entry to DONE, quotient is negated if the signs differ. Remainder takes the sign of the dividend (truncating division).
  - Latency is unchanged.
  - Divide-by-zero: quotient=all ones (-1), remainder=dividend.
  - MIN/-1: quotient=MIN (wraps), remainder=0, div_zero=0.
- Undefined: unsigned only; no sign registers are present.

Test Plan:
- BITS=8, dividend=100, divisor=7, out_ready=1 → quotient=14, remainder=2, div_zero=0. out_valid rises exactly 9 cycles after the accept edge, then in_ready=1 one cycle after the result handshake.
- dividend=3, divisor=10 → quotient=0, remainder=3. dividend=255, divisor=1 → quotient=255, remainder=0.
- dividend=5, divisor=0 → quotient=0xFF, remainder=5, div_zero=1, out_valid 1 cycle after accept. A following 9/3 → quotient 3, remainder 0, div_zero=0.
- 200/9 with out_ready=0 for 5 cycles after out_valid → outputs hold at 22/2, in_ready=0 and in_valid pulses ignored. out_ready=1 → IDLE next cycle.
- Assert rst at cycle 4 of CALC for 77/5 → all outputs return to reset values immediately with no out_valid. After release, 77/5 → quotient 15, remainder 2.
- SEQ_DIVIDER_SIGNED_EN defined:
  - -100/7 → quotient 0xF2 (-14), remainder 0xFE (-2).
  - 100/-7 → quotient 0xF2, remainder 0x02.
  - -128/-1 → quotient 0x80, remainder 0.
